// File: rtl/count_enable_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : count_enable_gen_pkg                                   |
// | Description : Shared state encoding and default widths for the      |
// |               count-enable generator.                                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package count_enable_gen_pkg;

   // Default prescaler divisor width and burst-length width
   localparam int c_DIV_W_DEFAULT   = 8;
   localparam int c_BURST_W_DEFAULT = 8;

   // Controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/count_enable_gen_rise_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rise_detect                                            |
// | Description : Rising-edge detector for a level input. The history   |
// |               register records "input was low at the last edge",    |
// |               so it clears on reset and a level held high across    |
// |               reset release never reads as a new edge.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic r_was_low;

   // Track whether the input was sampled low at the previous non-reset edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_was_low <= 1'b0;
      end else begin
         r_was_low <= ~sig;
      end
   end

   assign rise = sig & r_was_low;

endmodule
`default_nettype wire

// File: rtl/count_enable_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : count_enable_gen                                       |
// | Description : Generates a one-cycle enable pulse every div+1 clocks |
// |               for a downstream counter. Supports continuous run,    |
// |               fixed-length bursts with a done pulse, and single     |
// |               steps. Controls are edge-triggered (start/stop/step). |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module count_enable_gen
   import count_enable_gen_pkg::*;
#(
   parameter int DIV_W   = c_DIV_W_DEFAULT,
   parameter int BURST_W = c_BURST_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stop,
   input  logic               step,
   input  logic [DIV_W-1:0]   div,
   input  logic               burst,
   input  logic [BURST_W-1:0] burst_len,
   output logic               enable,
   output logic               running,
   output logic               done
);

   // One extra bit so a burst length of 0 (meaning 2^BURST_W) fits
   localparam int c_CNT_W = BURST_W + 1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DIV_W-1:0]   r_pre;
   logic [DIV_W-1:0]   w_pre_nxt;
   logic [DIV_W-1:0]   r_div_q;
   logic [DIV_W-1:0]   w_div_q_nxt;
   logic [BURST_W-1:0] r_len_q;
   logic [BURST_W-1:0] w_len_q_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic [c_CNT_W-1:0] w_cnt_inc;
   logic [c_CNT_W-1:0] w_len_ext;
   logic               r_enable;
   logic               w_enable_nxt;
   logic               r_done;
   logic               w_done_nxt;
   logic               w_ev_start;
   logic               w_ev_stop;
   logic               w_ev_step;

   rise_detect u_start_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (start),
      .rise  (w_ev_start)
   );

   rise_detect u_stop_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (stop),
      .rise  (w_ev_stop)
   );

   rise_detect u_step_rise (
      .clk   (clk),
      .reset (reset),
      .sig   (step),
      .rise  (w_ev_step)
   );

   // Pulse count after the pulse being issued now, and the burst target
   // with 0 expanded to 2^BURST_W
   assign w_cnt_inc = r_cnt + c_CNT_W'(1);
   assign w_len_ext = (r_len_q == '0) ? {1'b1, {BURST_W{1'b0}}}
                                      : {1'b0, r_len_q};

   // State and datapath registers; reset clears everything, which also
   // drops any pulse that was about to be issued
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_pre    <= '0;
         r_cnt    <= '0;
         r_div_q  <= '0;
         r_len_q  <= '0;
         r_enable <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_pre    <= w_pre_nxt;
         r_cnt    <= w_cnt_nxt;
         r_div_q  <= w_div_q_nxt;
         r_len_q  <= w_len_q_nxt;
         r_enable <= w_enable_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state and datapath decisions; stop beats start beats step
   always_comb begin
      w_state_nxt  = r_state;
      w_pre_nxt    = r_pre;
      w_cnt_nxt    = r_cnt;
      w_div_q_nxt  = r_div_q;
      w_len_q_nxt  = r_len_q;
      w_enable_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_ev_stop) begin
               if (w_ev_start) begin
                  w_state_nxt = RUN;
                  w_div_q_nxt = div;
                  w_len_q_nxt = burst_len;
                  w_pre_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else if (w_ev_step) begin
                  // Enable is high for the single cycle spent in STEP
                  w_state_nxt  = STEP;
                  w_enable_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (w_ev_stop) begin
               w_state_nxt = IDLE;
            end else if (r_pre == r_div_q) begin
               w_pre_nxt    = '0;
               w_enable_nxt = 1'b1;
               w_cnt_nxt    = w_cnt_inc;
               // The final burst pulse and done go out together
               if (burst && (w_cnt_inc == w_len_ext)) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end else begin
               w_pre_nxt = r_pre + DIV_W'(1);
            end
         end
         STEP: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Status output decoded from the state register
   always_comb begin
      running = (r_state == RUN);
   end

   assign enable = r_enable;
   assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_enable_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_count_enable_gen                                    |
// | Description : Directed self-checking bench for count_enable_gen.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_count_enable_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       stop;
   logic       step;
   logic [7:0] div;
   logic       burst;
   logic [7:0] burst_len;
   logic       enable;
   logic       running;
   logic       done;

   int vecs = 0;
   int errs = 0;

   count_enable_gen #(
      .DIV_W   (8),
      .BURST_W (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .step      (step),
      .div       (div),
      .burst     (burst),
      .burst_len (burst_len),
      .enable    (enable),
      .running   (running),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle before sampling
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic en, input logic run, input logic dn);
      chk({tag, ".enable"},  32'(enable),  32'(en));
      chk({tag, ".running"}, 32'(running), 32'(run));
      chk({tag, ".done"},    32'(done),    32'(dn));
   endtask

   int         pulses;
   int         dones;
   logic [7:0] ds_cnt;

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
      div = 8'd0; burst = 1'b0; burst_len = 8'd0;

      // Reset state
      cyc(); cyc();
      chk_out("reset", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      cyc();
      chk_out("post_reset", 1'b0, 1'b0, 1'b0);

      // Continuous mode, div=3; div changed to 0 mid-run must be ignored
      div = 8'd3; burst = 1'b0; start = 1'b1;
      cyc();
      chk_out("cont.start_edge", 1'b0, 1'b1, 1'b0);
      start = 1'b0; div = 8'd0;
      for (int n = 1; n <= 15; n++) begin
         cyc();
         chk_out($sformatf("cont.c%0d", n), (n % 4) == 0, 1'b1, 1'b0);
      end
      // Stop lands on the edge that would issue the 4th pulse
      stop = 1'b1;
      cyc();
      chk_out("cont.stop", 1'b0, 1'b0, 1'b0);
      stop = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         cyc();
         chk_out($sformatf("cont.after_stop%0d", n), 1'b0, 1'b0, 1'b0);
      end

      // Restart picks up div=0: enable every cycle
      start = 1'b1;
      cyc();
      chk_out("div0.start_edge", 1'b0, 1'b1, 1'b0);
      start = 1'b0;
      for (int n = 1; n <= 3; n++) begin
         cyc();
         chk_out($sformatf("div0.c%0d", n), 1'b1, 1'b1, 1'b0);
      end
      stop = 1'b1;
      cyc();
      chk_out("div0.stop", 1'b0, 1'b0, 1'b0);
      stop = 1'b0;
      cyc();

      // Burst of 5 at div=0
      div = 8'd0; burst = 1'b1; burst_len = 8'd5; start = 1'b1;
      cyc();
      chk_out("b5.start_edge", 1'b0, 1'b1, 1'b0);
      start = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         cyc();
         chk_out($sformatf("b5.c%0d", n), 1'b1, n < 5, n == 5);
      end
      cyc();
      chk_out("b5.after", 1'b0, 1'b0, 1'b0);

      // Burst boundary: length 0 means 256 pulses at period 2
      div = 8'd1; burst_len = 8'd0; start = 1'b1;
      cyc();
      start = 1'b0;
      pulses = 0; dones = 0; ds_cnt = 8'd0;
      for (int n = 1; n <= 520; n++) begin
         cyc();
         chk($sformatf("b256.enable.c%0d", n), 32'(enable), 32'(((n % 2) == 0) && (n <= 512)));
         chk($sformatf("b256.done.c%0d", n), 32'(done), 32'(n == 512));
         if (enable) begin
            pulses++;
            ds_cnt = ds_cnt + 8'd1;
         end
         if (done) dones++;
      end
      chk("b256.pulses", 32'(pulses), 32'd256);
      chk("b256.dones", 32'(dones), 32'd1);
      chk("b256.downstream", 32'(ds_cnt), 32'd0);
      chk("b256.running", 32'(running), 32'd0);

      // Start and stop together in IDLE: stop wins, stay idle
      burst = 1'b0; div = 8'd0; start = 1'b1; stop = 1'b1;
      cyc();
      chk_out("ss.edge", 1'b0, 1'b0, 1'b0);
      cyc();
      chk_out("ss.next", 1'b0, 1'b0, 1'b0);
      start = 1'b0; stop = 1'b0;
      cyc();

      // Step alone: one enable, not running
      step = 1'b1;
      cyc();
      chk_out("step.pulse", 1'b1, 1'b0, 1'b0);
      cyc();
      chk_out("step.after", 1'b0, 1'b0, 1'b0);
      cyc();
      chk_out("step.held", 1'b0, 1'b0, 1'b0);
      step = 1'b0;
      cyc();

      // Start and step together: start wins
      start = 1'b1; step = 1'b1;
      cyc();
      chk_out("st.edge", 1'b0, 1'b1, 1'b0);
      start = 1'b0; step = 1'b0;
      stop = 1'b1;
      cyc();
      chk_out("st.stop", 1'b0, 1'b0, 1'b0);
      stop = 1'b0;
      cyc();

      // Reset when pre == div_q-1, start held high through release
      div = 8'd3; burst = 1'b0; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      chk_out("rst.c1", 1'b0, 1'b1, 1'b0);
      cyc();
      chk_out("rst.c2", 1'b0, 1'b1, 1'b0);
      reset = 1'b1; start = 1'b1;
      cyc();
      chk_out("rst.edge", 1'b0, 1'b0, 1'b0);
      cyc();
      chk_out("rst.hold", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         cyc();
         chk_out($sformatf("rst.release%0d", n), 1'b0, 1'b0, 1'b0);
      end
      start = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/count_enable_gen.md
COUNT_ENABLE_GEN -- requirements
Module: count_enable_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter DIV_W, default 8, giving the prescaler divisor width.
REQ-003 The block SHALL have parameter BURST_W, default 8, giving the burst-length width.
REQ-004 Port clk: input, 1 bit, clock; all state updates on the rising edge.
REQ-005 Port reset: input, 1 bit, synchronous active-high reset.
REQ-006 Port start: input, 1 bit, level; a rising edge requests run.
REQ-007 Port stop: input, 1 bit, level; a rising edge requests halt.
REQ-008 Port step: input, 1 bit, level; a rising edge requests a single enable pulse.
REQ-009 Port div: input, DIV_W bits, enable period minus 1, in clk cycles.
REQ-010 Port burst: input, 1 bit; 1 selects burst mode, 0 selects continuous mode.
REQ-011 Port burst_len: input, BURST_W bits, pulses per burst; 0 means 2^BURST_W.
REQ-012 Port enable: output, 1 bit, registered one-cycle pulse that drives the downstream 8-bit counter's enable.
REQ-013 Port running: output, 1 bit, high while in RUN.
REQ-014 Port done: output, 1 bit, registered one-cycle pulse when a burst completes.

Function
REQ-015 Edge events SHALL be detected at edge k when the input is sampled 1 at k and 0 at k-1; the action SHALL take effect at edge k.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and STEP.
REQ-017 In IDLE, a start event SHALL enter RUN, latch div into div_q and burst_len into len_q, and clear the prescaler (pre) and the pulse counter (cnt) to 0.
REQ-018 In IDLE, a step event without a start event SHALL enter STEP.
REQ-019 STEP SHALL assert enable for exactly one cycle (the cycle after entry) and then return to IDLE.
REQ-020 In RUN, at each edge where pre==div_q: pre <= 0, enable <= 1, and cnt increments; otherwise pre <= pre+1 and enable <= 0.
REQ-021 The first enable SHALL occur div+1 cycles after the start edge, with period div+1; div=0 SHALL give enable every cycle.
REQ-022 Changes on div or burst_len while in RUN SHALL be ignored until the next start from IDLE.
REQ-023 In burst mode, at the edge issuing pulse number len_q, the FSM SHALL go to IDLE and assert done for one cycle, aligned with the final enable.
REQ-024 cnt SHALL be BURST_W+1 bits wide so that len_q=0 (2^BURST_W pulses) terminates correctly without wrap.
REQ-025 In continuous mode, cnt SHALL be ignored, and RUN SHALL persist until a stop event.
REQ-026 A stop event in RUN or STEP SHALL go to IDLE at that edge with enable forced to 0 in the next cycle; done SHALL NOT assert.
REQ-027 Simultaneous events SHALL be resolved with priority stop > start > step.
REQ-028 Start or step events occurring in RUN SHALL be ignored.
REQ-029 Burst completion coincident with a stop event SHALL take the stop path, with no done.

Reset
REQ-030 Reset SHALL override all inputs and set state=IDLE, pre=0, cnt=0, div_q=0, len_q=0, enable=0, running=0, done=0, and all edge-detect history registers to 0.
REQ-031 Reset asserted mid-RUN or mid-STEP SHALL suppress any pending pulse, so that enable=0 in the cycle after the reset edge.
REQ-032 An input held high through reset release SHALL NOT generate an event.

Structure
REQ-033 Package count_enable_gen_pkg SHALL hold the state enum (IDLE, RUN, STEP) and the default DIV_W and BURST_W constants.
REQ-034 Sub-module rise_detect SHALL be instantiated three times (start, stop, step); it contains a history register and a synchronous active-high reset.
REQ-035 The implementation SHALL contain no other sub-modules.

Verification
REQ-036 Continuous mode: div=3, burst=0, start pulse -> enable high on cycles 4, 8, 12... after the start edge; running=1; stop -> enable stays 0 from the next cycle.
REQ-037 Burst mode: div=0, burst=1, burst_len=5, start -> exactly 5 consecutive enable pulses, done coincident with the 5th, then running=0.
REQ-038 Burst boundary: div=1, burst_len=0 -> exactly 256 pulses at period 2, then done; the downstream counter driven by this block returns to its initial value.
REQ-039 Simultaneous events: start and stop rising together in IDLE -> remain IDLE; step alone in IDLE -> one enable pulse, running=0.
REQ-040 Reset mid-operation: reset asserted at pre==div_q-1 in RUN -> no enable pulse; all outputs 0; start held high across reset release -> no run.
REQ-041 Latching: div changed from 3 to 0 during RUN -> period stays 4 until stop and restart.
